// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S ADC receiver, 16-bit stereo pairs over a valid/ready handshake.
// Build option AUDIO_RX_PEAK_EN adds the left-channel peak meter (peak_left/peak_clr).
module audio_adc_rx (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        AUD_BCLK,
  input  logic        AUD_ADCLRCK,
  input  logic        AUD_ADCDAT,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] left_data,
  output logic [15:0] right_data,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr
`ifdef AUDIO_RX_PEAK_EN
  ,
  output logic [15:0] peak_left,
  input  logic        peak_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    HOLD
  } state_t;

  logic        r_bclk_m, r_bclk_s, r_bclk_q;
  logic        r_lrck_m, r_lrck_s;
  logic        r_dat_m, r_dat_s;
  logic        r_lrck_lat;
  logic        r_armed;
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [15:0] r_left_hold;
  logic        r_have_left;

  state_t      w_state_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [15:0] w_shift_nxt;
  logic        w_store;
  logic        w_err;
  logic        w_bit_ev;
  logic        w_lr_chg;
  logic [15:0] w_word;
  logic        w_store_l;
  logic        w_store_r;
  logic        w_pair;
  logic        w_accept;

  assign w_bit_ev  = r_bclk_s & ~r_bclk_q;
  assign w_lr_chg  = w_bit_ev & r_armed & (r_lrck_s != r_lrck_lat);
  assign w_word    = {r_shift[14:0], r_dat_s};
  assign w_store_l = w_store & ~r_lrck_s;
  assign w_store_r = w_store & r_lrck_s;
  assign w_pair    = w_store_r & r_have_left;
  assign w_accept  = sample_valid & sample_ready;

  // Two-flop synchronizers plus a delayed BCLK copy for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bclk_m <= 1'b0;
      r_bclk_s <= 1'b0;
      r_bclk_q <= 1'b0;
      r_lrck_m <= 1'b0;
      r_lrck_s <= 1'b0;
      r_dat_m  <= 1'b0;
      r_dat_s  <= 1'b0;
    end else begin
      r_bclk_m <= AUD_BCLK;
      r_bclk_s <= r_bclk_m;
      r_bclk_q <= r_bclk_s;
      r_lrck_m <= AUD_ADCLRCK;
      r_lrck_s <= r_lrck_m;
      r_dat_m  <= AUD_ADCDAT;
      r_dat_s  <= r_dat_m;
    end
  end

  // FSM state, bit counter, shifter and LRCK seen at the previous bit event
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_shift    <= 16'd0;
      r_lrck_lat <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      if (w_bit_ev) begin
        r_lrck_lat <= r_lrck_s;
        r_armed    <= 1'b1;
      end
    end
  end

  // Next state; the bit event that reveals an LRCK change is the I2S delay slot
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_store     = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_lr_chg) w_state_nxt = SKIP;
      end
      SKIP: begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = 5'd0;
        w_shift_nxt = 16'd0;
      end
      SHIFT: begin
        if (w_lr_chg) begin
          w_err       = 1'b1;
          w_state_nxt = SKIP;
          w_cnt_nxt   = 5'd0;
          w_shift_nxt = 16'd0;
        end else if (w_bit_ev) begin
          w_shift_nxt = w_word;
          w_cnt_nxt   = r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            w_store     = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_lr_chg) w_state_nxt = SKIP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Left word holding and same-frame pairing of left with right
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_left_hold <= 16'd0;
      r_have_left <= 1'b0;
    end else if (w_store_l) begin
      r_left_hold <= w_word;
      r_have_left <= 1'b1;
    end else if (w_pair || w_err) begin
      r_have_left <= 1'b0;
    end
  end

  // Output pair register with valid/ready handshake and sticky overrun
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sample_valid <= 1'b0;
      left_data    <= 16'd0;
      right_data   <= 16'd0;
      overrun      <= 1'b0;
    end else begin
      if (w_pair && (!sample_valid || w_accept)) begin
        sample_valid <= 1'b1;
        left_data    <= r_left_hold;
        right_data   <= w_word;
      end else if (w_accept) begin
        sample_valid <= 1'b0;
      end
      if (w_pair && sample_valid && !w_accept) overrun <= 1'b1;
      else if (overrun_clr)                    overrun <= 1'b0;
    end
  end

  // Short-channel error pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_err <= 1'b0;
    else          frame_err <= w_err;
  end

`ifdef AUDIO_RX_PEAK_EN
  logic [15:0] w_abs;

  assign w_abs = !w_word[15]          ? w_word :
                 (w_word == 16'h8000) ? 16'h7FFF :
                 (~w_word + 16'd1);

  // Left peak magnitude; a stored left word wins over a clear
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      peak_left <= 16'd0;
    end else if (w_store_l) begin
      if (w_abs > peak_left) peak_left <= w_abs;
    end else if (peak_clr) begin
      peak_left <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed and random I2S frames against a word-level model.
// Build with AUDIO_RX_PEAK_EN to also check the peak meter.
module tb_audio_adc_rx;

  logic        Clk;
  logic        Reset_n;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        frame_err;
  logic        overrun;
  logic        overrun_clr;
  logic [15:0] peak_left;
  logic        peak_clr;

  audio_adc_rx dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .left_data(left_data),
    .right_data(right_data),
    .frame_err(frame_err),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
`ifdef AUDIO_RX_PEAK_EN
    ,
    .peak_left(peak_left),
    .peak_clr(peak_clr)
`endif
  );

`ifndef AUDIO_RX_PEAK_EN
  assign peak_left = 16'd0;
`endif

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  int n_acc  = 0;
  int n_ferr = 0;
  logic [15:0] acc_l, acc_r;
  int ready_mode;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  hb, hl, hd;
  bit          m_armed, m_prev, m_active, m_have;
  int          m_n;
  int          m_acc;
  logic [15:0] m_left;
  logic        e_valid, e_ferr, e_ovr;
  logic [15:0] e_l, e_r, e_peak;

  always @(posedge Clk or negedge Reset_n) begin
    bit ev, lr, d, pair, err, stl, acc, drop;
    int mag;
    if (!Reset_n) begin
      hb = 0; hl = 0; hd = 0;
      m_armed = 0; m_prev = 0; m_active = 0; m_have = 0;
      m_n = 0; m_acc = 0; m_left = 0;
      e_valid = 0; e_ferr = 0; e_ovr = 0;
      e_l = 0; e_r = 0; e_peak = 0;
    end else begin
      // inputs are seen after two synchronizer stages
      ev = hb[1] && !hb[2];
      lr = hl[1];
      d  = hd[1];
      pair = 0; err = 0; stl = 0;
      if (ev) begin
        if (!m_armed) begin
          m_armed = 1;
        end else if (lr != m_prev) begin
          err = m_active && (m_n < 16);
          if (err) m_have = 0;
          m_active = 1;
          m_n = 0;
          m_acc = 0;
        end else if (m_active && m_n < 16) begin
          m_acc = m_acc * 2 + int'(d);
          m_n++;
          if (m_n == 16) begin
            if (!lr) begin
              m_left = m_acc[15:0];
              m_have = 1;
              stl = 1;
            end else if (m_have) begin
              pair = 1;
              m_have = 0;
            end
          end
        end
        m_prev = lr;
      end
      acc  = e_valid && sample_ready;
      drop = pair && e_valid && !acc;
      if (pair && !drop) begin
        e_valid = 1;
        e_l = m_left;
        e_r = m_acc[15:0];
      end else if (acc) begin
        e_valid = 0;
      end
      if (drop) e_ovr = 1;
      else if (overrun_clr) e_ovr = 0;
      e_ferr = err;
      if (stl) begin
        mag = m_acc[15] ? 65536 - m_acc[15:0] : m_acc[15:0];
        if (mag > 32767) mag = 32767;
        if (mag > int'(e_peak)) e_peak = mag[15:0];
      end else if (peak_clr) begin
        e_peak = 0;
      end
      hb = {hb[1:0], AUD_BCLK};
      hl = {hl[1:0], AUD_ADCLRCK};
      hd = {hd[1:0], AUD_ADCDAT};
    end
  end

  // accepted-pair log, sampled before the edge updates the DUT
  always @(posedge Clk) begin
    if (sample_valid && sample_ready) begin
      n_acc++;
      acc_l = left_data;
      acc_r = right_data;
    end
  end

  // per-cycle comparison against the model
  always @(negedge Clk) begin
    if (frame_err) n_ferr++;
    checks++;
    if ({sample_valid, left_data, right_data, frame_err, overrun} !==
        {e_valid, e_l, e_r, e_ferr, e_ovr}) begin
      errors++;
      if (nprint < 20)
        $display("FAIL cyc t=%0t act v=%b l=%h r=%h fe=%b ov=%b req v=%b l=%h r=%h fe=%b ov=%b",
                 $time, sample_valid, left_data, right_data, frame_err,
                 overrun, e_valid, e_l, e_r, e_ferr, e_ovr);
      nprint++;
    end
`ifdef AUDIO_RX_PEAK_EN
    checks++;
    if (peak_left !== e_peak) begin
      errors++;
      if (nprint < 20)
        $display("FAIL peak t=%0t actual=%h required=%h",
                 $time, peak_left, e_peak);
      nprint++;
    end
`endif
  end

  // ready / clear drivers
  initial begin
    forever begin
      @(negedge Clk);
      case (ready_mode)
        0: sample_ready = 1'b1;
        1: sample_ready = 1'b0;
        2: begin
          sample_ready = 1'($urandom % 2);
          overrun_clr  = ($urandom % 32 == 0);
          peak_clr     = ($urandom % 64 == 0);
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  // one I2S channel slot: edge 0 is the delay bit, edges 1..vbits the word
  task automatic send_slot(input logic lr, input int w, input logic [31:0] val,
                           input int vbits, input int rst_at, input bit hs);
    logic d;
    for (int i = 0; i < w; i++) begin
      if (i == rst_at) begin
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_left", 32'(left_data), 0);
        chk("rst_right", 32'(right_data), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        repeat (3) @(negedge Clk);
        #2 Reset_n = 1'b1;
      end
      if (i >= 1 && i <= vbits) d = val[vbits - i];
      else d = 1'($urandom % 2);
      AUD_BCLK    = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT  = d;
      repeat (4) @(negedge Clk);
      AUD_BCLK = 1'b1;
      if (hs && i == 16) begin
        repeat (2) @(negedge Clk);
        sample_ready = 1'b1;
        @(negedge Clk);
        sample_ready = 1'b0;
        @(negedge Clk);
      end else begin
        repeat (4) @(negedge Clk);
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int w, input bit hs);
    send_slot(1'b0, w, {16'd0, l}, 16, -1, 1'b0);
    send_slot(1'b1, w, {16'd0, r}, 16, -1, hs);
  endtask

  initial begin
    int a0, f0, w, vb;
    Reset_n = 1'b0;
    AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    sample_ready = 1'b0; overrun_clr = 1'b0; peak_clr = 1'b0;
    ready_mode = 3;
    wait_n(3);
    chk("reset_valid", 32'(sample_valid), 0);
    chk("reset_left", 32'(left_data), 0);
    chk("reset_right", 32'(right_data), 0);
    chk("reset_ferr", 32'(frame_err), 0);
    chk("reset_ovr", 32'(overrun), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // basic frame, consumer always ready
    ready_mode = 0;
    a0 = n_acc;
    send_slot(1'b1, 17, 0, 0, -1, 1'b0);
    send_frame(16'h1234, 16'hABCD, 17, 1'b0);
    wait_n(8);
    chk("basic_count", n_acc - a0, 1);
    chk("basic_left", 32'(acc_l), 32'h1234);
    chk("basic_right", 32'(acc_r), 32'hABCD);
    chk("basic_ovr", 32'(overrun), 0);
    chk("model_left", 32'(e_l), 32'h1234);

    // consumer stalled: second pair dropped
    ready_mode = 1;
    send_frame(16'h0001, 16'h0002, 17, 1'b0);
    send_frame(16'h0003, 16'h0004, 17, 1'b0);
    wait_n(8);
    chk("ovr_valid", 32'(sample_valid), 1);
    chk("ovr_left", 32'(left_data), 32'h0001);
    chk("ovr_right", 32'(right_data), 32'h0002);
    chk("ovr_flag", 32'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge Clk);
    overrun_clr = 1'b0;
    #1;
    chk("ovr_clr", 32'(overrun), 0);
    ready_mode = 0;
    wait_n(4);

    // short left channel (9 bits) then a good frame
    a0 = n_acc;
    f0 = n_ferr;
    send_slot(1'b0, 10, 32'h1FF, 9, -1, 1'b0);
    send_slot(1'b1, 17, 32'h7777, 16, -1, 1'b0);
    wait_n(4);
    chk("short_ferr", n_ferr - f0, 1);
    chk("short_novalid", n_acc - a0, 0);
    send_frame(16'h5A5A, 16'hC3C3, 17, 1'b0);
    wait_n(8);
    chk("short_next_count", n_acc - a0, 1);
    chk("short_next_left", 32'(acc_l), 32'h5A5A);
    chk("short_next_right", 32'(acc_r), 32'hC3C3);

    // 24-bit slots, extra bits ignored
    send_slot(1'b0, 25, 32'h8000A5, 24, -1, 1'b0);
    send_slot(1'b1, 25, 32'h12345F, 24, -1, 1'b0);
    wait_n(8);
    chk("wide_left", 32'(acc_l), 32'h8000);
    chk("wide_right", 32'(acc_r), 32'h1234);
`ifdef AUDIO_RX_PEAK_EN
    chk("wide_peak", 32'(peak_left), 32'h7FFF);
`endif

    // reset in the right channel at bit 7
    ready_mode = 1;
    send_frame(16'hAAAA, 16'h5555, 17, 1'b0);
    send_slot(1'b0, 17, 32'h1111, 16, -1, 1'b0);
    send_slot(1'b1, 17, 32'h2222, 16, 7, 1'b0);
    ready_mode = 0;
    a0 = n_acc;
    send_frame(16'h0F0F, 16'hF0F0, 20, 1'b0);
    wait_n(8);
    chk("post_rst_count", n_acc - a0, 1);
    chk("post_rst_left", 32'(acc_l), 32'h0F0F);
    chk("post_rst_right", 32'(acc_r), 32'hF0F0);

    // pair completes in the same cycle as an accepting handshake
    ready_mode = 3;
    sample_ready = 1'b0;
    send_frame(16'hC0DE, 16'hBEEF, 17, 1'b0);
    send_frame(16'h1357, 16'h2468, 17, 1'b1);
    wait_n(2);
    chk("hs_valid", 32'(sample_valid), 1);
    chk("hs_left", 32'(left_data), 32'h1357);
    chk("hs_right", 32'(right_data), 32'h2468);
    chk("hs_ovr", 32'(overrun), 0);
    ready_mode = 0;
    wait_n(4);

    // random frames, random ready and clears
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom % 8 == 0) w = 1 + int'($urandom % 16);
        else w = 17 + int'($urandom % 16);
        vb = w - 1;
        send_slot(1'(ch), w, $urandom, vb, -1, 1'b0);
      end
    end
    ready_mode = 0;
    overrun_clr = 1'b0;
    peak_clr = 1'b0;
    wait_n(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have port Clk  input  1  system clock (50 MHz); all logic in this domain.
REQ-002 SHALL have port Reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have port AUD_BCLK  input  1  codec bit clock; asynchronous to Clk, at most Clk/8.
REQ-004 SHALL have port AUD_ADCLRCK  input  1  codec ADC word select; low = left, high = right.
REQ-005 SHALL have port AUD_ADCDAT  input  1  codec serial ADC data; I2S format, MSB first.
REQ-006 SHALL have port sample_valid  output  1  stereo pair available.
REQ-007 SHALL have port sample_ready  input  1  consumer accepts the pair.
REQ-008 SHALL have port left_data  output  16  left sample, two's complement.
REQ-009 SHALL have port right_data  output  16  right sample, two's complement.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a short channel.
REQ-011 SHALL have port overrun  output  1  sticky flag; a pair was dropped.
REQ-012 SHALL have port overrun_clr  input  1  synchronous clear of overrun.
REQ-013 SHALL have port peak_left  output  16  unsigned left peak magnitude (AUDIO_RX_PEAK_EN only).
REQ-014 SHALL have port peak_clr  input  1  synchronous clear of peak_left (AUDIO_RX_PEAK_EN only).

Function
REQ-015 SHALL pass AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT through two-flop synchronizers, then detect BCLK rising edges and LRCK transitions on the synchronized copies.
REQ-016 SHALL sample synchronized ADCDAT and LRCK only in the Clk cycle of a detected BCLK rising edge ("bit event").
REQ-017 SHALL use the FSM states IDLE, SKIP, SHIFT and HOLD.
REQ-018 SHALL move IDLE->SKIP on the first bit event whose LRCK differs from the LRCK latched at the previous bit event.
REQ-019 SHALL ignore the first bit event in SKIP (I2S one-bit delay), then enter SHIFT with the 5-bit counter at 0.
REQ-020 SHALL shift ADCDAT MSB-first into a 16-bit register in SHIFT, one bit per bit event; after the 16th bit it SHALL store the word into the left or right holding register, selected by latched LRCK, and enter HOLD.
REQ-021 SHALL ignore any bits beyond 16 while in HOLD, and SHALL enter SKIP at the next LRCK transition.
REQ-022 SHALL, on an LRCK transition in SHIFT with fewer than 16 bits received, discard the partial word, pulse frame_err for one cycle, and enter SKIP for the new channel.
REQ-023 SHALL treat a pair as complete when a right word is stored after a left word in the same frame; a right word with no preceding left word SHALL be discarded.
REQ-024 SHALL, on pair completion, load left_data/right_data and assert sample_valid in the next Clk cycle.
REQ-025 SHALL hold sample_valid high until a cycle with sample_valid && sample_ready; left_data/right_data SHALL stay stable while valid.
REQ-026 SHALL, if a pair completes in the same cycle as an accepting handshake, load the new pair and keep sample_valid at 1 with no overrun.
REQ-027 SHALL, if a pair completes while valid is high and ready is low, drop the new pair, keep the old one, and set overrun.
REQ-028 SHALL give set priority over overrun_clr when both occur in the same cycle.

Reset
REQ-029 SHALL, while Reset_n = 0, force FSM = IDLE, counter = 0, shift register = 0, synchronizers = 0, sample_valid = 0, left_data = right_data = 0, frame_err = 0, overrun = 0, peak_left = 0.
REQ-030 SHALL discard any partial word on reset assertion mid-frame, and after release SHALL wait for a fresh LRCK transition before capturing.

Configuration
REQ-031 SHALL, with AUDIO_RX_PEAK_EN defined, update peak_left to max(peak_left, |left word|) at each stored left word, saturating |-32768| to 32767; peak_clr SHALL zero it, losing to a same-cycle update.
REQ-032 SHALL, without AUDIO_RX_PEAK_EN, omit the peak_left and peak_clr ports and all associated logic.

Verification
REQ-033 SHALL cover: I2S frame with left 16'h1234, right 16'hABCD, ready = 1 -> one valid pulse with those exact values, overrun = 0.
REQ-034 SHALL cover: two frames (16'h0001/16'h0002, then 16'h0003/16'h0004) with ready held 0 -> data stays 16'h0001/16'h0002, overrun = 1; overrun_clr -> overrun = 0.
REQ-035 SHALL cover: LRCK toggled after 9 left bits -> one frame_err pulse, no valid, next full frame captured correctly.
REQ-036 SHALL cover: 24-bit slots carrying 16'h8000 in the top bits -> left_data = 16'h8000, extra bits ignored; with AUDIO_RX_PEAK_EN, peak_left = 16'h7FFF.
REQ-037 SHALL cover: Reset_n pulsed low at bit 7 of the right channel -> all outputs 0; next complete frame captured normally.
REQ-038 SHALL cover: pair completion in the same cycle as an accepting handshake -> new data presented, valid stays 1, no overrun.
